// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch/PC unit and its helpers.
//   - 4-bit opcode encodings (instr[15:12]) and the HLT instruction word
//   - branch condition-code encodings (instr[11:9])
//   - flag bit positions inside the {Z,V,N} vector
//   - fetch FSM state enum and the reset PC
//   - branch_offset(): sign-extended, word-scaled branch displacement
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_BR   = 4'hD;
    localparam logic [3:0] OP_PCS  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Fed to the decoder whenever no live instruction is present; HLT
    // asserts no RegWrite, so it is a safe bubble.
    localparam logic [15:0] INSTR_HLT = {OP_HLT, 12'h000};

    localparam logic [15:0] RESET_PC = 16'h0000;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OVF = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    // Positions inside the {Z,V,N} flag vector.
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [1:0] {
        StFetch  = 2'b00,
        StWait   = 2'b01,
        StHalted = 2'b10
    } fetch_state_e;

    // sext(imm9) << 1, as a 16-bit two's-complement offset.
    function automatic logic [15:0] branch_offset(input logic [8:0] imm);
        return {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/branch_cond.sv
// branch_cond: evaluates a 3-bit branch condition code against the flags.
// Ports:
//   ccc   [2:0] in  : condition code from instr[11:9]
//   flags [2:0] in  : registered {Z,V,N}
//   taken       out : condition holds
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        unique case (ccc)
            CC_NE:  taken = !z;
            CC_EQ:  taken = z;
            CC_GT:  taken = !z && !n;
            CC_LT:  taken = n;
            CC_GE:  taken = z || (!z && !n);
            CC_LE:  taken = n || z;
            CC_OVF: taken = v;
            CC_UNC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, instruction fetch FSM and flag register.
// Build option: define FETCH_IMEM_WAIT_EN to honour imem_ready and use the
// WAIT state; otherwise imem_ready is ignored and one instruction is
// fetched every cycle.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   imem_addr/req        : fetch address (= PC) and request
//   imem_rdata/ready     : fetched word and its valid strobe
//   instr/instr_valid    : instruction to decoder and its liveness
//   branch_in/jump_in/hlt_in : decoder control
//   rs_data              : register-indirect branch target
//   flags_in/flags_we    : ALU {Z,V,N} and per-bit write enables
//   pc_plus2             : PC+2 for PCS writeback
//   halted               : core stopped
module fetch_pc_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        branch_in,
    input  logic        jump_in,
    input  logic        hlt_in,
    input  logic [15:0] rs_data,
    input  logic [2:0]  flags_in,
    input  logic [2:0]  flags_we,
    output logic [15:0] pc_plus2,
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [2:0]   flags_q, flags_d;
    logic         ready_eff;
    logic         taken;

`ifdef FETCH_IMEM_WAIT_EN
    assign ready_eff = imem_ready;
`else
    logic unused_imem_ready;
    assign unused_imem_ready = imem_ready;
    assign ready_eff = 1'b1;
`endif

    assign imem_req    = (state_q != StHalted);
    assign imem_addr   = pc_q;
    assign halted      = (state_q == StHalted);
    assign instr_valid = ready_eff && (state_q != StHalted);
    assign instr       = instr_valid ? imem_rdata : INSTR_HLT;
    assign pc_plus2    = pc_q + 16'd2;

    // Uses flags_q, so a flag write in this cycle cannot affect this branch.
    branch_cond u_branch_cond (
        .ccc   (instr[11:9]),
        .flags (flags_q),
        .taken (taken)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        case (state_q)
            StFetch, StWait: begin
                if (instr_valid) begin
                    flags_d = (flags_we & flags_in) | (~flags_we & flags_q);
                    if (hlt_in) begin
                        state_d = StHalted;
                    end else begin
                        state_d = StFetch;
                        if (branch_in && taken) begin
                            pc_d = jump_in ? rs_data
                                           : pc_plus2 + branch_offset(instr[8:0]);
                        end else begin
                            pc_d = pc_plus2;
                        end
                    end
                end else begin
`ifdef FETCH_IMEM_WAIT_EN
                    state_d = StWait;
`else
                    state_d = StFetch;
`endif
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench for fetch_pc_unit. The bench plays the
// decoder and instruction memory; each step's expected next PC is queued
// and compared against imem_addr at the start of the following step.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] instr;
    logic        instr_valid;
    logic        branch_in;
    logic        jump_in;
    logic        hlt_in;
    logic [15:0] rs_data;
    logic [2:0]  flags_in;
    logic [2:0]  flags_we;
    logic [15:0] pc_plus2;
    logic        halted;

    int checks;
    int failures;
    logic [15:0] sb[$];

    localparam logic [15:0] ADD = 16'h0123;
    localparam logic [15:0] HLT = 16'hF000;

    fetch_pc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .branch_in   (branch_in),
        .jump_in     (jump_in),
        .hlt_in      (hlt_in),
        .rs_data     (rs_data),
        .flags_in    (flags_in),
        .flags_we    (flags_we),
        .pc_plus2    (pc_plus2),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_addr(output logic [15:0] exp_addr);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            exp_addr = 16'hxxxx;
        end else begin
            exp_addr = sb.pop_front();
        end
    endtask

    // Starts and ends at a falling edge.
    task automatic step(input string tag, input logic [15:0] rdata, input logic rdy,
                        input logic br, input logic jmp, input logic hlt,
                        input logic [15:0] rs, input logic [2:0] fin, input logic [2:0] fwe,
                        input logic exp_valid, input logic [15:0] exp_next);
        logic [15:0] exp_addr;
        pop_addr(exp_addr);
        chk({tag, ".imem_addr"}, imem_addr, exp_addr);
        chk({tag, ".pc_plus2"}, pc_plus2, exp_addr + 16'd2);
        chk({tag, ".imem_req"}, 16'(imem_req), 16'd1);
        chk({tag, ".halted"}, 16'(halted), 16'd0);
        imem_rdata = rdata;
        imem_ready = rdy;
        branch_in  = br;
        jump_in    = jmp;
        hlt_in     = hlt;
        rs_data    = rs;
        flags_in   = fin;
        flags_we   = fwe;
        #1;
        chk({tag, ".instr_valid"}, 16'(instr_valid), 16'(exp_valid));
        chk({tag, ".instr"}, instr, exp_valid ? rdata : HLT);
        sb.push_back(exp_next);
        @(negedge clk);
    endtask

    task automatic halted_step(input logic [15:0] hold_pc);
        logic [15:0] exp_addr;
        pop_addr(exp_addr);
        chk("halt.imem_addr", imem_addr, exp_addr);
        chk("halt.imem_req", 16'(imem_req), 16'd0);
        chk("halt.halted", 16'(halted), 16'd1);
        imem_rdata = ADD;
        imem_ready = 1'b1;
        hlt_in     = 1'b0;
        branch_in  = 1'b1;
        jump_in    = 1'b1;
        rs_data    = 16'h4444;
        #1;
        chk("halt.instr_valid", 16'(instr_valid), 16'd0);
        chk("halt.instr", instr, HLT);
        sb.push_back(hold_pc);
        @(negedge clk);
    endtask

    // Asserts reset at a falling edge, checks the async effect, and releases
    // it on a later falling edge; the first fetch is then expected at 0000.
    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        branch_in  = 1'b0;
        jump_in    = 1'b0;
        hlt_in     = 1'b0;
        flags_we   = 3'b000;
        #1;
        chk("rst.imem_addr", imem_addr, 16'h0000);
        chk("rst.halted", 16'(halted), 16'd0);
        chk("rst.imem_req", 16'(imem_req), 16'd1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(16'h0000);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        imem_rdata = 16'h0000;
        imem_ready = 1'b0;
        branch_in  = 1'b0;
        jump_in    = 1'b0;
        hlt_in     = 1'b0;
        rs_data    = 16'h0000;
        flags_in   = 3'b000;
        flags_we   = 3'b000;
        @(negedge clk);
        do_reset();

        // Straight-line ADDs.
        step("add0", ADD, 1, 0, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h0002);
        step("add1", ADD, 1, 0, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h0004);
        step("add2", ADD, 1, 0, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h0006);
        // B uncond +8 to 0010 while setting Z=1.
        step("b_unc", 16'hCE04, 1, 1, 0, 0, 16'h0, 3'b100, 3'b111, 1, 16'h0010);
        // B EQ -4 with Z=1: taken.
        step("beq_t", 16'hC3FE, 1, 1, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h000E);
        // Clear Z.
        step("clr_z", ADD, 1, 0, 0, 0, 16'h0, 3'b000, 3'b100, 1, 16'h0010);
        // B EQ with Z=0 (same-cycle write of Z=1 must not be seen): not taken.
        step("beq_nt", 16'hC3FE, 1, 1, 0, 0, 16'h0, 3'b100, 3'b100, 1, 16'h0012);
        // B EQ +2 now sees Z=1.
        step("beq_new", 16'hC201, 1, 1, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h0016);
        // BR uncond to ABCC.
        step("br_unc", 16'hDE00, 1, 1, 1, 0, 16'hABCC, 3'b000, 3'b000, 1, 16'hABCC);
        // BR NE with Z=1: not taken.
        step("br_nt", 16'hD000, 1, 1, 1, 0, 16'h1234, 3'b000, 3'b000, 1, 16'hABCE);
        // Set V only, then BR on overflow to FFFE.
        step("set_v", ADD, 1, 0, 0, 0, 16'h0, 3'b010, 3'b010, 1, 16'hABD0);
        step("br_ovf", 16'hDC00, 1, 1, 1, 0, 16'hFFFE, 3'b000, 3'b000, 1, 16'hFFFE);
        // Wrap past the top of memory.
        step("wrap", ADD, 1, 0, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h0000);
        // B uncond +0x1E to 0020.
        step("b_0020", 16'hCE0F, 1, 1, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h0020);
`ifdef FETCH_IMEM_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            step("wait", ADD, 0, 1, 1, 1, 16'h5555, 3'b111, 3'b111, 0, 16'h0020);
        end
`endif
        step("hlt", HLT, 1, 0, 0, 1, 16'h0, 3'b000, 3'b000, 1, 16'h0020);
        for (int i = 0; i < 12; i++) begin
            halted_step(16'h0020);
        end

        do_reset();
        step("post0", ADD, 1, 0, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h0002);
        step("post1", ADD, 1, 0, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h0004);
        // Flags were cleared by reset: B EQ must not be taken.
        step("post_beq", 16'hC201, 1, 1, 0, 0, 16'h0, 3'b000, 3'b000, 1, 16'h0006);
        begin
            logic [15:0] exp_addr;
            pop_addr(exp_addr);
            chk("final.imem_addr", imem_addr, exp_addr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
